ascon_round_ctrl: RTL and testbench

Sequencer for the ASCON permutation datapath. It accepts a permutation request, loads the state register, then steps the round counter for p^12, p^8 or p^6. Each cycle it drives the 4-bit round-constant index into the existing round-constant ROM (index → 64-bit constant). It sits between the mode/AEAD controller and the permutation round datapath.

---
 rtl/ascon_pkg.sv | 30 +++
 rtl/ascon_round_ctrl.sv | 82 ++++++++
 tb/tb_ascon_round_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON permutation sequencer.
package ascon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RSEL_12 = 2'b00;
  localparam logic [1:0] RSEL_8  = 2'b01;
  localparam logic [1:0] RSEL_6  = 2'b10;

  localparam logic [3:0] ROUNDS_A  = 4'd12;
  localparam logic [3:0] ROUNDS_B8 = 4'd8;
  localparam logic [3:0] ROUNDS_B6 = 4'd6;
  localparam logic [3:0] RC_BASE   = 4'd12;

  // Reserved encoding 11 falls back to the full-strength permutation.
  function automatic logic [3:0] rounds_decode(input logic [1:0] sel,
                                               input logic [3:0] nr_a);
    case (sel)
      RSEL_8:  rounds_decode = ROUNDS_B8;
      RSEL_6:  rounds_decode = ROUNDS_B6;
      default: rounds_decode = nr_a;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the ASCON permutation: load, p^12/p^8/p^6 rounds, done.
module ascon_round_ctrl
  import ascon_pkg::*;
#(
  parameter int unsigned ROUNDS_A = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] rounds_sel,
  input  logic       abort,
  output logic       ready,
  output logic       load_en,
  output logic       round_en,
  output logic [3:0] rc_index,
  output logic       last_round,
  output logic       done
);

  localparam logic [3:0] NR_A = 4'(ROUNDS_A);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] nr, nr_nxt;
  logic       is_last;

  assign is_last = (cnt == nr - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      nr    <= NR_A;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      nr    <= nr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nr_nxt    = nr;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
            nr_nxt    = rounds_decode(rounds_sel, NR_A);
          end
        end
        LOAD:  state_nxt = ROUND;
        ROUND: begin
          cnt_nxt = cnt + 4'd1;
          if (is_last) state_nxt = DONE;
        end
        DONE:  state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Shorter permutations use the tail of the constant table: 12 - nr + cnt.
  always_comb begin
    ready      = (state == IDLE);
    load_en    = (state == LOAD);
    round_en   = (state == ROUND);
    done       = (state == DONE);
    last_round = (state == ROUND) && is_last;
    rc_index   = '0;
    if (state == ROUND) rc_index = RC_BASE - nr + cnt;
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Scoreboard bench for ascon_round_ctrl: per-cycle expected outputs are queued at issue.
module tb_ascon_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] rounds_sel;
  logic       abort;
  logic       ready, load_en, round_en, last_round, done;
  logic [3:0] rc_index;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // {ready, load_en, round_en, last_round, done, rc_index}
  logic [8:0] exp_q[$];
  logic [8:0] obs;
  localparam logic [8:0] V_IDLE = {5'b10000, 4'd0};

  ascon_round_ctrl #(.ROUNDS_A(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rounds_sel (rounds_sel),
    .abort      (abort),
    .ready      (ready),
    .load_en    (load_en),
    .round_en   (round_en),
    .rc_index   (rc_index),
    .last_round (last_round),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign obs = {ready, load_en, round_en, last_round, done, rc_index};

  function automatic void push_idle();
    exp_q.push_back(V_IDLE);
  endfunction

  function automatic void push_round(input int unsigned idx, input logic last);
    exp_q.push_back({3'b001, last, 1'b0, 4'(idx)});
  endfunction

  function automatic void push_run(input int unsigned nr);
    exp_q.push_back({5'b01000, 4'd0});
    for (int unsigned c = 0; c < nr; c++) push_round(12 - nr + c, c == nr - 1);
    exp_q.push_back({5'b00001, 4'd0});
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rounds_sel = 2'b00; abort = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL reset_async obs=%b exp=%b", obs, V_IDLE);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL reset_held obs=%b exp=%b", obs, V_IDLE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run(input logic [1:0] sel, input int unsigned nr, input string name);
    int unsigned dones = 0;
    logic [8:0]  e;
    start = 1'b1; rounds_sel = sel;
    push_run(nr); push_idle();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s obs=%b exp=%b", name, obs, e);
      end
      if (done) dones++;
      start = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL %s_done_count got=%0d exp=1", name, dones);
    end
  endtask

  task automatic test_ignore_inputs();
    int unsigned dones = 0;
    int unsigned k = 0;
    logic [8:0]  e;
    start = 1'b1; rounds_sel = 2'b01;
    push_run(8); push_idle();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ignore k=%0d obs=%b exp=%b", k, obs, e);
      end
      if (done) dones++;
      start      = (k >= 2 && k <= 5);
      rounds_sel = 2'(k + 2);
      k++;
    end
    start = 1'b0;
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_abort();
    int unsigned dones = 0;
    int unsigned k = 0;
    logic [8:0]  e;
    start = 1'b1; rounds_sel = 2'b00;
    exp_q.push_back({5'b01000, 4'd0});
    for (int unsigned c = 0; c < 5; c++) push_round(c, 1'b0);
    push_idle();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort k=%0d obs=%b exp=%b", k, obs, e);
      end
      if (done) dones++;
      start = 1'b0; abort = 1'b0;
      if (k == 5) abort = 1'b1;
      if (k == 6) begin
        start = 1'b1; rounds_sel = 2'b10;
        push_run(6); push_idle();
      end
      k++;
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL abort_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    start = 1'b1; rounds_sel = 2'b00;
    exp_q.push_back({5'b01000, 4'd0});
    for (int unsigned c = 0; c < 3; c++) push_round(c, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL pre_rst obs=%b exp=%b", obs, e);
      end
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL mid_rst obs=%b exp=%b", obs, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int unsigned dones = 0;
    logic [8:0]  e;
    start = 1'b1; rounds_sel = 2'b01;
    for (int unsigned r = 0; r < 3; r++) begin
      push_run(8); push_idle();
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b obs=%b exp=%b", obs, e);
      end
      if (done) dones++;
      if (dones == 3) start = 1'b0;
    end
    checks++;
    if (dones !== 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=3", dones);
    end
  endtask

  initial begin
    test_reset();
    test_run(2'b00, 12, "p12");
    test_run(2'b01, 8, "p8");
    test_run(2'b10, 6, "p6");
    test_run(2'b11, 12, "p12_rsvd");
    test_ignore_inputs();
    test_abort();
    test_async_reset();
    test_run(2'b00, 12, "post_rst");
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
